permutation_ctrl: RTL and testbench

- Sequencing controller for the single-round ASCON permutation datapath (mux, Pc, Ps, Pl, state register with enable).
- Accepts a start request with a round-count mode, then drives the datapath's state-select, register-enable and round-index inputs for a pa (12-round) or pb (6-round) permutation.
- Signals completion with a one-cycle done pulse, at which point the datapath state register holds the permuted state.
- Sits between the ASCON mode FSM (initialisation / associated data / plaintext / finalisation) and the permutation datapath.

---
 rtl/ascon_pack.sv | 14 +
 rtl/permutation_ctrl_round_counter.sv | 28 ++
 rtl/permutation_ctrl.sv | 88 ++++++++
 tb/tb_permutation_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation control path.
package ascon_pack;

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} ctrl_state_t;

  localparam int         NB_ROUNDS_MAX = 12;
  localparam logic [3:0] LAST_ROUND    = 4'd11;

  // Rounds always end at index 11, so a shorter permutation starts later.
  function automatic logic [3:0] first_round(input int rounds);
    return 4'(NB_ROUNDS_MAX - rounds);
  endfunction

endpackage

// File: rtl/permutation_ctrl_round_counter.sv
// 4-bit loadable up-counter supplying the round index to the datapath.
module round_counter (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load_i)     count_d = load_val_i;
    else if (inc_i) count_d = count_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/permutation_ctrl.sv
// Sequences the single-round ASCON datapath through a pa or pb permutation.
module permutation_ctrl
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       sel_o,
  output logic       en_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       ready_o,
  output logic       done_o
);

  ctrl_state_t state_q, state_d;
  logic        sel_q, en_q, busy_q, ready_q, done_q;
  logic        load, inc, last;
  logic [3:0]  count, load_val;

  assign last     = (count == LAST_ROUND);
  assign load_val = mode_i ? first_round(ROUNDS_B) : first_round(ROUNDS_A);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = FIRST;
        end else begin
          state_d = IDLE;
        end
      end
      FIRST, RUN: begin
        if (last) begin
          state_d = DONE;
        end else begin
          inc     = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they carry no path from start_i.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= (state_d == RUN);
      en_q    <= (state_d == FIRST) || (state_d == RUN);
      busy_q  <= (state_d == FIRST) || (state_d == RUN);
      ready_q <= (state_d == IDLE)  || (state_d == DONE);
      done_q  <= (state_d == DONE);
    end
  end

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .load_val_i (load_val),
    .inc_i      (inc),
    .count_o    (count)
  );

  assign sel_o   = sel_q;
  assign en_o    = en_q;
  assign busy_o  = busy_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign round_o = count;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Directed bench for permutation_ctrl: reset, pa/pb runs, busy starts, back-to-back, mid-run reset, ROUNDS_B override.
module tb_permutation_ctrl;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic       reset_i, start_i, mode_i, start2_i, mode2_i;
  logic       sel_o, en_o, busy_o, ready_o, done_o;
  logic [3:0] round_o;
  logic       sel2, en2, busy2, ready2, done2;
  logic [3:0] round2;

  int checks = 0;
  int errors = 0;

  permutation_ctrl dut (
    .clock_i (clock_i), .reset_i (reset_i), .start_i (start_i), .mode_i (mode_i),
    .sel_o   (sel_o),   .en_o    (en_o),    .round_o (round_o),
    .busy_o  (busy_o),  .ready_o (ready_o), .done_o  (done_o)
  );

  permutation_ctrl #(.ROUNDS_A(12), .ROUNDS_B(8)) dut_b8 (
    .clock_i (clock_i), .reset_i (reset_i), .start_i (start2_i), .mode_i (mode2_i),
    .sel_o   (sel2),    .en_o    (en2),     .round_o (round2),
    .busy_o  (busy2),   .ready_o (ready2),  .done_o  (done2)
  );

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // Packed as {sel, en, round[3:0], busy, ready, done}.
  task automatic expect_outs(input string tag, input bit use2, input logic s, input logic e,
                             input logic [3:0] r, input logic b, input logic rd, input logic d);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = use2 ? {sel2, en2, round2, busy2, ready2, done2}
               : {sel_o, en_o, round_o, busy_o, ready_o, done_o};
    exp = {s, e, r, b, rd, d};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed sel/en/round/busy/ready/done=%b_%b_%0d_%b_%b_%b expected %b_%b_%0d_%b_%b_%b",
             tag, obs[8], obs[7], obs[6:3], obs[2], obs[1], obs[0],
             exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One permutation from a single-cycle start; a start pulse is injected at round 'poke'.
  task automatic run_perm(input string tag, input bit use2, input logic m,
                          input int first, input int poke);
    if (use2) begin start2_i = 1'b1; mode2_i = m; end
    else      begin start_i  = 1'b1; mode_i  = m; end
    step();
    start_i = 1'b0; start2_i = 1'b0;
    expect_outs({tag, "_first"}, use2, 1'b0, 1'b1, 4'(first), 1'b1, 1'b0, 1'b0);
    for (int r = first + 1; r <= 11; r++) begin
      if (!use2) begin
        start_i = (r == poke);
        mode_i  = (r == poke) ? ~m : m;
      end
      step();
      expect_outs($sformatf("%s_run%0d", tag, r), use2, 1'b1, 1'b1, 4'(r), 1'b1, 1'b0, 1'b0);
    end
    start_i = 1'b0;
    step();
    expect_outs({tag, "_done"}, use2, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b1);
    step();
    expect_outs({tag, "_idle"}, use2, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; start2_i = 1'b0; mode2_i = 1'b0;
    #1;
    expect_outs("reset_hold", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(); step();
    reset_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      expect_outs($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    expect_outs("idle_b8", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    run_perm("pa", 1'b0, 1'b0, 0, -1);
    run_perm("pb", 1'b0, 1'b1, 6, -1);
    run_perm("pa_busy_start", 1'b0, 1'b0, 0, 5);
    run_perm("pb_busy_start", 1'b0, 1'b1, 6, 8);

    // start held high in pb: FIRST directly follows each DONE, one done every 7 cycles.
    start_i = 1'b1; mode_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_outs($sformatf("b2b%0d_first", k), 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
      for (int r = 7; r <= 11; r++) begin
        step();
        expect_outs($sformatf("b2b%0d_run%0d", k, r), 1'b0, 1'b1, 1'b1, 4'(r), 1'b1, 1'b0, 1'b0);
      end
      step();
      expect_outs($sformatf("b2b%0d_done", k), 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b1);
    end
    start_i = 1'b0;
    step();
    expect_outs("b2b_idle", 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a pa run, between clock edges.
    start_i = 1'b1; mode_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    expect_outs("mid_round5", 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    #2 reset_i = 1'b1;
    #1;
    expect_outs("mid_reset_async", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    reset_i = 1'b0;
    step();
    expect_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    run_perm("pa_after_reset", 1'b0, 1'b0, 0, -1);

    run_perm("b8_pb", 1'b1, 1'b1, 4, -1);
    run_perm("b8_pa", 1'b1, 1'b0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
